fp_square_seq: RTL
==================

# fp_square_seq

Sequential IEEE-754 single-precision squarer computing out = in × in with a valid/ready handshake on both sides. It is the inverse companion to the combinational square-root block in the FFT magnitude path. It re-squares magnitudes for power-spectrum output and for self-checking square-root results. It replaces a full combinational multiplier with a 24-cycle shift-add mantissa datapath.

## Interface
- No parameters; format fixed at binary32 (1/8/23).
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in  input  32  operand, sampled when in_valid && in_ready
- in_valid  input  1  operand present
- in_ready  output  1  block idle, can accept an operand
- out  output  32  result, stable while out_valid && !out_ready
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result

## Operation
- Classification happens on accept. Zero means exponent 0, including denormals, which are flushed. Inf means exponent 0xFF with mantissa 0. NaN means exponent 0xFF with mantissa ≠ 0.
- Special results, all taking the bypass path:
  - zero or denormal → 0x00000000
  - ±inf → 0x7F800000
  - NaN → input with the sign bit cleared
- Result sign is always 0.
- Normal operand setup: M = {1, in[22:0]} (24 bit).
- Normal exponent: E = 2·in[30:23] − 127, computed in a 10-bit signed register.
- Mantissa product P (48 bit) uses radix-2 shift-add, 24 iterations, LSB first. Each step: if multiplier bit is 1, P += M << i.
- Normalize:
  - If P[47] = 1: mantissa = P[46:24], E += 1.
  - Else: mantissa = P[45:23].
- Rounding is truncation toward zero. No round bits are kept.
- Range limits, checked after normalize:
  - E ≥ 255 → 0x7F800000 (overflow to +inf).
  - E ≤ 0 → 0x00000000 (underflow, flush to zero).
- FSM states:
  - IDLE: in_ready = 1. On accept, go to BYPASS for a special operand, else to MUL with counter = 0.
  - MUL: one shift-add per cycle. Go to NORM after counter = 23.
  - NORM: normalize, range-check, load out. Go to DONE.
  - BYPASS: load the special result into out. Go to DONE.
  - DONE: out_valid = 1. On out_ready, go to IDLE.
- Iteration counter is 5 bit and never exceeds 23.

## Timing
- Reset values: in_ready = 0 while rst is high, then 1 in IDLE. out_valid = 0, out = 0, FSM = IDLE, counter = 0, P = 0.
- Accept happens on the rising edge where in_valid && in_ready.
- Normal operand: MUL covers accept+1 … accept+24, NORM is at accept+25, and out_valid rises at accept+26.
- Special operand: BYPASS at accept+1, out_valid at accept+2.
- in_ready is 0 from the cycle after accept until the cycle after output handoff. There is no pipelining and one operand is in flight at most.
- Handoff occurs on the edge where out_valid && out_ready. The cycle after, out_valid = 0 and in_ready = 1.
- in_valid asserted in the handoff cycle is not accepted, since in_ready = 0. Minimum issue interval is 27 cycles (normal) or 3 cycles (special), with out_ready held high.
- out_ready low: out and out_valid hold indefinitely, and the FSM stays in DONE.
- Changes on in after accept have no effect.
- rst asserted mid-operation, in any state, aborts immediately and asynchronously to reset values. The in-flight result is discarded.
- out_ready is ignored outside DONE.

## Test plan
- 0x40400000 (3.0) → out 0x41100000 (9.0). out_valid exactly 26 cycles after accept, and in_ready low throughout.
- 0xC0000000 (−2.0) → 0x40800000 (4.0). Then 0x3FC00000 (1.5) → 0x40100000 (2.25). The 1.5 case exercises the P[47] = 1 normalize path.
- Specials, each with out_valid at accept+2:
  - 0x80000000 → 0x00000000
  - 0x00000001 (denormal) → 0x00000000
  - 0xFF800000 → 0x7F800000
  - 0xFFC00001 → 0x7FC00001
- Range: 0x60AD78EC (≈1e20) → 0x7F800000 (overflow). 0x1E3CE508 (≈1e-20) → 0x00000000 (underflow).
- Backpressure: hold out_ready = 0 for 10 cycles after out_valid. Required: out stable, in_ready = 0, and a new in_valid is ignored. Release gives a single handoff, and the next operand is accepted the cycle after.
- Reset mid-op: assert rst at accept+12. Required: out_valid = 0, out = 0, in_ready = 1 after release. A following 0x40400000 still yields 0x41100000.

Source files
------------

// File: rtl/fp_square_seq_if.sv
// Valid/ready operand and result channels for the sequential single-precision squarer.
interface fp_square_seq_if;
  logic [31:0] inData;
  logic        inValid;
  logic        inReady;
  logic [31:0] outData;
  logic        outValid;
  logic        outReady;

  modport master (
    output inData, inValid, outReady,
    input  inReady, outData, outValid
  );

  modport slave (
    input  inData, inValid, outReady,
    output inReady, outData, outValid
  );
endinterface

// File: rtl/fp_square_seq.sv
// Sequential binary32 squarer: 24-step LSB-first shift-add mantissa product, truncating
// normalize, flush-to-zero / saturate-to-inf range handling, specials bypass the multiplier.
module fp_square_seq (
  input logic           clk,
  input logic           rst,
  fp_square_seq_if.slave bus
);

  typedef enum logic [2:0] {IDLE, MUL, NORM, BYPASS, DONE} state_t;

  state_t             state_q;
  logic [4:0]         count_q;
  logic [47:0]        prod_q;
  logic [47:0]        prod_d;
  logic [23:0]        mcand_q;
  logic signed [9:0]  exp_q;
  logic signed [9:0]  exp_d;
  logic [31:0]        bypass_q;
  logic [31:0]        bypass_d;
  logic [31:0]        out_q;
  logic               outValid_q;

  logic [7:0]         inExp;
  logic               isSpecial;
  logic               normHi;
  logic [22:0]        normMan;
  logic signed [9:0]  normExp;
  logic [31:0]        normOut;

  assign inExp     = bus.inData[30:23];
  assign isSpecial = (inExp == 8'h00) || (inExp == 8'hFF);

  // Inf and NaN both reduce to the input with its sign cleared; denormals flush to zero.
  assign bypass_d  = (inExp == 8'h00) ? 32'h0000_0000 : {1'b0, bus.inData[30:0]};
  assign exp_d     = $signed({1'b0, inExp, 1'b0}) - 10'sd127;

  assign prod_d    = prod_q + (mcand_q[count_q] ? ({24'd0, mcand_q} << count_q) : 48'd0);

  assign normHi    = prod_q[47];
  assign normMan   = normHi ? prod_q[46:24] : prod_q[45:23];
  assign normExp   = exp_q + $signed({9'd0, normHi});

  always_comb begin
    normOut = {1'b0, normExp[7:0], normMan};
    if (normExp >= 10'sd255) begin
      normOut = 32'h7F80_0000;
    end else if (normExp <= 10'sd0) begin
      normOut = 32'h0000_0000;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= 5'd0;
      prod_q     <= 48'd0;
      mcand_q    <= 24'd0;
      exp_q      <= 10'sd0;
      bypass_q   <= 32'd0;
      out_q      <= 32'd0;
      outValid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.inValid) begin
            if (isSpecial) begin
              bypass_q <= bypass_d;
              state_q  <= BYPASS;
            end else begin
              mcand_q  <= {1'b1, bus.inData[22:0]};
              exp_q    <= exp_d;
              prod_q   <= 48'd0;
              count_q  <= 5'd0;
              state_q  <= MUL;
            end
          end
        end
        MUL: begin
          prod_q <= prod_d;
          if (count_q == 5'd23) begin
            count_q <= 5'd0;
            state_q <= NORM;
          end else begin
            count_q <= count_q + 5'd1;
          end
        end
        NORM: begin
          out_q      <= normOut;
          outValid_q <= 1'b1;
          state_q    <= DONE;
        end
        BYPASS: begin
          out_q      <= bypass_q;
          outValid_q <= 1'b1;
          state_q    <= DONE;
        end
        DONE: begin
          if (bus.outReady) begin
            outValid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Ready is decoded from state so it drops immediately while reset is held.
  assign bus.inReady  = (state_q == IDLE) && !rst;
  assign bus.outData  = out_q;
  assign bus.outValid = outValid_q;

endmodule
